// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, reads a combinational imem and holds the result in an
// IF/ID register handed to decode over valid/ready; flags sticky fetch faults.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          IMEM_DEPTH      = 1024,
    parameter int          IMEM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]                imem_dout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       fault,
    output logic [31:0]                fault_pc
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] fault_pc_next;
    logic            pc_bad;
    logic            fire;
    logic            drop;
    logic            set_fault;

    assign imem_addr = pc[IMEM_ADDR_WIDTH+1:2];

    // Anything at or beyond IMEM_DEPTH words faults rather than wrapping to word 0.
    assign pc_bad = (pc[1:0] != 2'b00) || ((pc >> 2) >= XLEN'(IMEM_DEPTH));

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        fault_pc_next = fault_pc;
        fire          = 1'b0;
        drop          = 1'b0;
        set_fault     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    drop = 1'b1;
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_next    = FAULT;
                        set_fault     = 1'b1;
                        fault_pc_next = redirect_pc;
                    end else begin
                        pc_next = redirect_pc;
                    end
                end else if (pc_bad) begin
                    drop          = 1'b1;
                    state_next    = FAULT;
                    set_fault     = 1'b1;
                    fault_pc_next = pc;
                end else if (!out_valid || out_ready) begin
                    fire    = 1'b1;
                    pc_next = pc + XLEN'(4);
                end
            end
            FAULT: begin
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            fault    <= 1'b0;
            fault_pc <= '0;
        end else begin
            state <= state_next;
            if (set_fault) begin
                fault    <= 1'b1;
                fault_pc <= fault_pc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
        end else if (drop) begin
            out_valid <= 1'b0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_pc    <= pc;
            out_inst  <= imem_dout;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch stage.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [9:0]  imem_addr;
    logic [31:0] imem_dout;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        fault;
    logic [31:0] fault_pc;

    logic        start_end = 1'b0;
    logic [9:0]  e_imem_addr;
    logic [31:0] e_imem_dout;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_fault;
    logic [31:0] e_fault_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_dout   = 32'h1000_0000 | {22'd0, imem_addr};
    assign e_imem_dout = 32'h1000_0000 | {22'd0, e_imem_addr};

    inst_fetch u_dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_addr(imem_addr), .imem_dout(imem_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fault(fault), .fault_pc(fault_pc)
    );

    inst_fetch #(.RESET_PC(32'h0000_0FFC)) u_dut_end (
        .clk(clk), .reset(reset), .start(start_end),
        .imem_addr(e_imem_addr), .imem_dout(e_imem_dout),
        .out_valid(e_valid), .out_ready(1'b1),
        .out_pc(e_pc), .out_inst(e_inst),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .fault(e_fault), .fault_pc(e_fault_pc)
    );

    // Behavioural model: phase 0 = waiting for start, 1 = fetching, 2 = faulted.
    int          m_phase;
    logic [31:0] m_pc, m_opc, m_oinst, m_fpc;
    logic        m_valid, m_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_phase = 0; m_pc = 32'h0; m_valid = 1'b0; m_opc = '0;
            m_oinst = '0; m_fault = 1'b0; m_fpc = '0;
        end else if (m_phase == 0) begin
            if (start) m_phase = 1;
        end else if (m_phase == 1) begin
            if (redirect_valid) begin
                m_valid = 1'b0;
                if (redirect_pc % 4 != 0) begin
                    m_phase = 2; m_fault = 1'b1; m_fpc = redirect_pc;
                end else begin
                    m_pc = redirect_pc;
                end
            end else if (m_pc % 4 != 0 || m_pc >= 32'd4096) begin
                m_phase = 2; m_fault = 1'b1; m_fpc = m_pc; m_valid = 1'b0;
            end else if (!m_valid || out_ready) begin
                m_opc   = m_pc;
                m_oinst = 32'h1000_0000 + m_pc / 4;
                m_valid = 1'b1;
                m_pc    = m_pc + 4;
            end
        end
    endtask

    task automatic check_all();
        check("imem_addr", {22'd0, imem_addr}, (m_pc / 4) % 1024);
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("out_pc", out_pc, m_opc);
        check("out_inst", out_inst, m_oinst);
        check("fault", {31'd0, fault}, {31'd0, m_fault});
        check("fault_pc", fault_pc, m_fpc);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        // reset state
        reset = 1'b1; tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_addr", {22'd0, imem_addr}, 32'd0);
        reset = 1'b0;

        // first fetch latency and streaming
        out_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
        check("t1_valid0", {31'd0, out_valid}, 32'd0);
        tick();
        check("t1_valid1", {31'd0, out_valid}, 32'd1);
        check("t1_pc0", out_pc, 32'h0);
        check("t1_inst0", out_inst, 32'h1000_0000);
        tick(); check("t1_pc4", out_pc, 32'h4);
        tick(); check("t1_pc8", out_pc, 32'h8);

        // stall while out_pc=8
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_pc", out_pc, 32'h8);
            check("t2_inst", out_inst, 32'h1000_0002);
            check("t2_addr", {22'd0, imem_addr}, 32'd3);
        end
        out_ready = 1'b1; tick();
        check("t2_resume", out_pc, 32'hC);

        // reset mid-run with a valid output
        reset = 1'b1; tick(); reset = 1'b0;
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        check("t6_addr", {22'd0, imem_addr}, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        check("t6_restart", {31'd0, out_valid}, 32'd1);
        check("t6_pc0", out_pc, 32'h0);
        tick(); tick();
        check("t3_pre", out_pc, 32'h8);

        // redirect
        redirect_valid = 1'b1; redirect_pc = 32'h40; tick(); redirect_valid = 1'b0;
        check("t3_flush", {31'd0, out_valid}, 32'd0);
        tick();
        check("t3_pc", out_pc, 32'h40);
        check("t3_inst", out_inst, 32'h1000_0010);

        // misaligned redirect, then inputs ignored
        redirect_valid = 1'b1; redirect_pc = 32'h42; tick(); redirect_valid = 1'b0;
        check("t4_fault", {31'd0, fault}, 32'd1);
        check("t4_fpc", fault_pc, 32'h42);
        check("t4_valid", {31'd0, out_valid}, 32'd0);
        start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            out_ready = i[0];
            tick();
            check("t4_sticky", {31'd0, fault}, 32'd1);
            check("t4_fpc_hold", fault_pc, 32'h42);
            check("t4_addr_hold", {22'd0, imem_addr}, 32'h11);
        end
        start = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;

        // last word of imem, then range fault
        reset = 1'b1; tick(); reset = 1'b0;
        start_end = 1'b1; tick(); start_end = 1'b0;
        tick();
        check("t5_valid", {31'd0, e_valid}, 32'd1);
        check("t5_pc", e_pc, 32'hFFC);
        check("t5_inst", e_inst, 32'h1000_03FF);
        tick();
        check("t5_fault", {31'd0, e_fault}, 32'd1);
        check("t5_fpc", e_fault_pc, 32'h1000);
        check("t5_valid0", {31'd0, e_valid}, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int r;
            reset = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 31);
            if (r == 0)
                redirect_pc = {$urandom_range(0, 1023), 2'b00} | 32'd2;
            else if (r == 1)
                redirect_pc = 32'h1000 + {$urandom_range(0, 255), 2'b00};
            else if (r < 6)
                redirect_pc = 32'hFF0 + {$urandom_range(0, 3), 2'b00};
            else
                redirect_pc = {$urandom_range(0, 1023), 2'b00};
            tick();
        end
        reset = 1'b0; start = 1'b0; redirect_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
